// File: rtl/decr_timer_if.sv
// Load handshake, control and status bundle for decr_timer.
interface decr_timer_if #(
  parameter int WIDTH = 3
);
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, en, abort,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, en, abort,
    output load_ready, count, busy, done
  );
endinterface

// File: rtl/decr_timer.sv
// Loadable countdown timer with ripple-borrow decrement and done pulse.
// Optional AUTO_RELOAD_EN: periodic reload of the last loaded value.
module decr_timer #(
  parameter int WIDTH = 3
) (
  input logic        clk,
  input logic        rst,
  decr_timer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;

  // Bit i flips when every lower bit is zero (borrow ripples up).
  function automatic logic [WIDTH-1:0] decr(
    input logic [WIDTH-1:0] a
  );
    logic [WIDTH-1:0] r;
    logic             z;
    z = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = a[i] ^ z;
      z    = z & ~a[i];
    end
    return r;
  endfunction

  logic take;
  assign take = bus.load_valid & bus.load_ready;

  assign bus.load_ready = (state != RUN) & ~bus.abort;
  assign bus.count      = count_q;
  assign bus.busy       = (state == RUN);

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
  logic             done_q;
  assign bus.done = done_q;
`else
  assign bus.done = (state == DONE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= '0;
`ifdef AUTO_RELOAD_EN
      reload  <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
`ifdef AUTO_RELOAD_EN
      done_q <= 1'b0;
`endif
      if (bus.abort) begin
        state   <= IDLE;
        count_q <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (take) begin
              count_q <= bus.load_value;
`ifdef AUTO_RELOAD_EN
              reload  <= bus.load_value;
`endif
              if (bus.load_value != '0) begin
                state <= RUN;
              end else begin
                state <= DONE;
`ifdef AUTO_RELOAD_EN
                done_q <= 1'b1;
`endif
              end
            end else begin
              count_q <= '0;
              state   <= IDLE;
            end
          end
          RUN: begin
            if (bus.en) begin
              if (count_q == WIDTH'(1)) begin
`ifdef AUTO_RELOAD_EN
                count_q <= reload;
                done_q  <= 1'b1;
`else
                count_q <= '0;
                state   <= DONE;
`endif
              end else begin
                count_q <= decr(count_q);
              end
            end
          end
          default: begin
            state   <= IDLE;
            count_q <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_decr_timer.sv
// Scoreboard bench for decr_timer: cycle model pushes expectations,
// sampled DUT outputs pop and compare.
module tb_decr_timer;
  localparam int W = 3;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;
`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic rst;

  decr_timer_if #(.WIDTH(W)) bus ();

  decr_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] c;
    logic         b;
    logic         d;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_busy = 0;

  int m_st  = S_IDLE;
  int m_cnt = 0;
  int m_rl  = 0;
  bit m_rel = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit lv, input int val, input bit e, input bit ab);
    m_rel = 1'b0;
    if (ab) begin
      m_st  = S_IDLE;
      m_cnt = 0;
    end else if (m_st == S_RUN) begin
      if (e) begin
        if (m_cnt == 1) begin
          if (AUTO) begin
            m_cnt = m_rl;
            m_rel = 1'b1;
          end else begin
            m_cnt = 0;
            m_st  = S_DONE;
          end
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end else if (lv) begin
      m_cnt = val;
      m_rl  = val;
      m_st  = (val != 0) ? S_RUN : S_DONE;
    end else begin
      m_cnt = 0;
      m_st  = S_IDLE;
    end
  endtask

  task automatic cyc(input bit lv, input int val, input bit e, input bit ab);
    exp_t x;
    @(negedge clk);
    bus.load_valid = lv;
    bus.load_value = val[W-1:0];
    bus.en         = e;
    bus.abort      = ab;
    #1;
    check("load_ready", int'(bus.load_ready), int'(m_st != S_RUN && !ab));
    model(lv, val, e, ab);
    x.c = m_cnt[W-1:0];
    x.b = (m_st == S_RUN);
    x.d = (m_st == S_DONE) || m_rel;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("count", int'(bus.count), int'(x.c));
    check("busy", int'(bus.busy), int'(x.b));
    check("done", int'(bus.done), int'(x.d));
    if (bus.done) n_done++;
    if (bus.busy) n_busy++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.en         = 1'b0;
    bus.abort      = 1'b0;
    #3;
    check("rst_count", int'(bus.count), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", int'(bus.load_ready), 1);

    // one-shot load 5
    n_done = 0;
    cyc(1'b1, 5, 1'b1, 1'b0);
    idle(6);
    check("oneshot_dones", n_done, 1);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // every start value down to done
    for (int v = 7; v >= 1; v--) begin
      n_done = 0;
      cyc(1'b1, v, 1'b1, 1'b0);
      idle(v);
      check("exh_done", n_done, 1);
      cyc(1'b0, 0, 1'b0, 1'b1);
    end

    // enable gating with ignored loads in RUN
    cyc(1'b1, 4, 1'b1, 1'b0);
    cyc(1'b1, 6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 6, 1'b0, 1'b0);
    check("gate_hold", int'(bus.count), 3);
    idle(4);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // zero load
    n_busy = 0;
    n_done = 0;
    cyc(1'b1, 0, 1'b1, 1'b0);
    idle(2);
    check("zero_busy", n_busy, 0);
    check("zero_done", n_done, 1);

    // abort with simultaneous load
    cyc(1'b1, 5, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    n_done = 0;
    cyc(1'b1, 2, 1'b1, 1'b1);
    idle(3);
    check("abort_done", n_done, 0);
    cyc(1'b1, 3, 1'b1, 1'b1);
    check("abort_idle_cnt", int'(bus.count), 0);

    // back-to-back load in DONE cycle
    cyc(1'b1, 0, 1'b1, 1'b0);
    cyc(1'b1, 3, 1'b1, 1'b0);
    check("b2b_count", int'(bus.count), 3);
    idle(4);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // async reset mid-countdown
    cyc(1'b1, 5, 1'b1, 1'b0);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", int'(bus.count), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    m_st  = S_IDLE;
    m_cnt = 0;
    m_rl  = 0;
    m_rel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", int'(bus.load_ready), 1);
    idle(2);

`ifdef AUTO_RELOAD_EN
    n_done = 0;
    n_busy = 0;
    cyc(1'b1, 3, 1'b1, 1'b0);
    idle(10);
    check("auto_dones", n_done, 3);
    check("auto_busy", n_busy, 11);
    cyc(1'b0, 0, 1'b1, 1'b1);
    check("auto_abort_cnt", int'(bus.count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
